// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//
// Produces the 3-bit channel index and enable for a downstream 3-to-8 one-hot
// decoder. Steps through the eight channels in ascending or descending order,
// holds each enabled channel for a programmable dwell, and skips channels
// whose mask bit is clear.
//
// Optional feature macro: SCAN_SEQUENCER_BLANK_EN
//   Defined   : every channel change inserts one BLANK cycle (sel already shows
//               the new channel, en=0) to give the decoder a dead time.
//   Undefined : channels change back-to-back with en continuously high.
//
// Ports
//   clk       in   1        rising-edge clock
//   rst       in   1        synchronous active-high reset
//   start     in   1        pulse: begin scanning (acted on only in IDLE)
//   stop      in   1        pulse: end scanning, return to IDLE
//   dwell     in   DWELL_W  cycles per channel (0 behaves as 1)
//   mask      in   8        channel enables, bit i=1 visits channel i
//   dir       in   1        0 = ascending, 1 = descending
//   sel       out  3        channel index to decoder
//   en        out  1        decoder enable
//   wrap      out  1        one-cycle pulse on return to the first channel
//   busy      out  1        high whenever not IDLE
//   state_dbg out  2        current FSM state (IDLE=0, SCAN=1, BLANK=2)
//
// Control semantics: start and stop are level-sampled single-cycle pulses with
// no handshake. Priority is rst > stop > start; start outside IDLE is ignored.
// All outputs are registered.
// -----------------------------------------------------------------------------
module scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         mask,
  input  logic               dir,
  output logic [2:0]         sel,
  output logic               en,
  output logic               wrap,
  output logic               busy,
  output logic [1:0]         state_dbg
);

`ifdef SCAN_SEQUENCER_BLANK_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic               en_q, en_d;
  logic               wrap_q, wrap_d;
  logic               busy_q, busy_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [2:0]         first_ch;
  logic [2:0]         next_ch;
  logic               next_wrap;
  logic               next_found;

  // A dwell of zero would otherwise never reach the advance point.
  assign dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

  // First enabled channel: lowest set bit ascending, highest set bit descending.
  // The loop direction is chosen so the last assignment wins.
  always_comb begin
    first_ch = 3'd0;
    if (!dir) begin
      for (int i = 7; i >= 0; i--) begin
        if (mask[i]) first_ch = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (mask[i]) first_ch = 3'(i);
      end
    end
  end

  // Nearest set bit after sel in the scan direction. The signed position
  // leaving 0..7 means the search stepped across the 7/0 boundary. With a
  // single enabled channel the search ends at distance 8, which always counts
  // as a wrap.
  always_comb begin
    next_ch    = sel_q;
    next_wrap  = 1'b0;
    next_found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      int p;
      p = dir ? (int'(sel_q) - k) : (int'(sel_q) + k);
      if (!next_found && mask[p[2:0]]) begin
        next_found = 1'b1;
        next_ch    = p[2:0];
        next_wrap  = (p < 0) || (p > 7);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    wrap_d  = 1'b0;
    busy_d  = busy_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop && (mask != 8'd0)) begin
          state_d = SCAN;
          sel_d   = first_ch;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = dwell_eff;
        end
      end

      SCAN: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q > DWELL_W'(1)) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (mask == 8'd0) begin
          // Nothing left to visit; sel keeps the last channel shown.
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          sel_d  = next_ch;
          wrap_d = next_wrap;
`ifdef SCAN_SEQUENCER_BLANK_EN
          state_d = BLANK;
          en_d    = 1'b0;
`else
          en_d    = 1'b1;
          cnt_d   = dwell_eff;
`endif
        end
      end

`ifdef SCAN_SEQUENCER_BLANK_EN
      BLANK: begin
        if (stop) begin
          state_d = IDLE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else begin
          // Dwell is sampled here, on entry to the new channel.
          state_d = SCAN;
          en_d    = 1'b1;
          cnt_d   = dwell_eff;
        end
      end
`endif

      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign sel       = sel_q;
  assign en        = en_q;
  assign wrap      = wrap_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//
// Scoreboard bench for scan_sequencer. A behavioural model advances on every
// rising edge from the same sampled inputs and pushes the expected registered
// outputs {sel,en,wrap,busy} into exp_q; a monitor on the falling edge pops and
// compares. Directed phases follow the scanning scenarios, then a randomized
// phase mixes start/stop pulses, mask, dir and dwell changes.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

  localparam int DW = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic [DW-1:0] dwell;
  logic [7:0]    mask;
  logic          dir;
  logic [2:0]    sel;
  logic          en;
  logic          wrap;
  logic          busy;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .dwell     (dwell),
    .mask      (mask),
    .dir       (dir),
    .sel       (sel),
    .en        (en),
    .wrap      (wrap),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: "which channel is lit and for how many more cycles"
  // ---------------------------------------------------------------------------
  bit         m_active = 0;
  bit         m_blank  = 0;
  int         m_left   = 0;
  logic [2:0] m_sel    = 3'd0;
  bit         m_en     = 0;
  bit         m_wrap   = 0;
  bit         m_busy   = 0;

  function automatic int eff_dwell(input logic [DW-1:0] d);
    return (d == 0) ? 1 : int'(d);
  endfunction

  function automatic int first_enabled(input logic [7:0] m, input logic d);
    if (!d) begin
      for (int c = 0; c < 8; c++) if (m[c]) return c;
    end else begin
      for (int c = 7; c >= 0; c--) if (m[c]) return c;
    end
    return 0;
  endfunction

  // Walks k = 1..8 steps around the ring; a wrap happened if the walk crossed
  // the 7/0 seam, i.e. more steps than room left before the seam.
  task automatic next_enabled(input int s, input logic [7:0] m, input logic d,
                              output int nxt, output bit wr);
    nxt = s;
    wr  = 0;
    for (int k = 1; k <= 8; k++) begin
      int c;
      c = d ? (s + 8 - k) % 8 : (s + k) % 8;
      if (m[c]) begin
        nxt = c;
        wr  = d ? (k > s) : (s + k > 7);
        return;
      end
    end
  endtask

  task automatic model_step();
    int nxt;
    bit wr;
    m_wrap = 0;
    if (rst) begin
      m_active = 0; m_blank = 0; m_left = 0;
      m_sel = 3'd0; m_en = 0; m_busy = 0;
    end else if (!m_active) begin
      if (start && !stop && mask != 8'd0) begin
        m_active = 1;
        m_sel    = 3'(first_enabled(mask, dir));
        m_en     = 1;
        m_busy   = 1;
        m_left   = eff_dwell(dwell);
      end
    end else if (stop) begin
      m_active = 0; m_blank = 0; m_en = 0; m_busy = 0;
    end else if (m_blank) begin
      m_blank = 0;
      m_en    = 1;
      m_left  = eff_dwell(dwell);
    end else if (m_left > 1) begin
      m_left--;
    end else if (mask == 8'd0) begin
      m_active = 0; m_en = 0; m_busy = 0;
    end else begin
      next_enabled(int'(m_sel), mask, dir, nxt, wr);
      m_sel  = 3'(nxt);
      m_wrap = wr;
`ifdef SCAN_SEQUENCER_BLANK_EN
      m_blank = 1;
      m_en    = 0;
`else
      m_left  = eff_dwell(dwell);
`endif
    end
  endtask

  always @(posedge clk) begin
    model_step();
    exp_q.push_back({m_sel, m_en, m_wrap, m_busy});
  end

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sel",  {5'd0, sel},  {5'd0, e[5:3]});
      chk("en",   {7'd0, en},   {7'd0, e[2]});
      chk("wrap", {7'd0, wrap}, {7'd0, e[1]});
      chk("busy", {7'd0, busy}, {7'd0, e[0]});
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    dwell = 8'd3; mask = 8'h00; dir = 1'b0;
    run(3);
    rst = 1'b0;
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_sel",  {5'd0, sel},  8'd0);

    // Full ascending scan, dwell 3
    mask = 8'hFF; dwell = 8'd3; dir = 1'b0;
    pulse_start();
    run(60);
    pulse_stop();

    // Masked descending scan
    mask = 8'b1010_0101; dir = 1'b1; dwell = 8'd2;
    pulse_start();
    run(30);
    pulse_stop();

    // Single channel, zero dwell
    mask = 8'h10; dwell = 8'd0; dir = 1'b0;
    pulse_start();
    run(10);
    pulse_stop();

    // Stop mid-dwell on channel 3, then simultaneous start+stop in IDLE
    mask = 8'hFF; dwell = 8'd4; dir = 1'b0;
    pulse_start();
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (sel == 3'd3 && en) found = 1;
      else tick();
    end
    chk("wait_sel3", {7'd0, found}, 8'd1);
    pulse_stop();
    chk("stop_en",   {7'd0, en},   8'd0);
    chk("stop_busy", {7'd0, busy}, 8'd0);
    chk("stop_sel",  {5'd0, sel},  8'd3);
    run(2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", {7'd0, busy}, 8'd0);
    run(4);

    // Mask cleared mid-dwell, then start with empty mask
    mask = 8'hFF; dwell = 8'd5;
    pulse_start();
    run(7);
    mask = 8'h00;
    run(12);
    chk("mask0_busy", {7'd0, busy}, 8'd0);
    pulse_start();
    run(4);
    chk("mask0_start_busy", {7'd0, busy}, 8'd0);

    // Two channels, dwell 2 (shows blank cycle when the macro is on)
    mask = 8'h03; dwell = 8'd2; dir = 1'b0;
    pulse_start();
    run(15);
    pulse_stop();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      stop  = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0)
        mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) dwell = 8'($urandom_range(0, 4));
      if (!busy && mask == 8'h00 && $urandom_range(0, 3) == 0) mask = 8'h5A;
      tick();
    end
    start = 1'b0; stop = 1'b0;
    run(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
